// File: rtl/tilt_pkg.sv
// Shared types for the tilt entry path: FSM encoding, sample classes,
// tilt_state output codes and the default thresholds.
package tilt_pkg;

  localparam int DEF_THRESH = 80;
  localparam int DEF_HYST   = 20;

  typedef enum logic [2:0] {
    ST_NEUTRAL  = 3'd0,
    ST_ARM_POS  = 3'd1,
    ST_ARM_NEG  = 3'd2,
    ST_HELD_POS = 3'd3,
    ST_HELD_NEG = 3'd4
  } tilt_st_e;

  typedef enum logic [1:0] {
    CLS_REL  = 2'd0,
    CLS_BAND = 2'd1,
    CLS_POS  = 2'd2,
    CLS_NEG  = 2'd3
  } tilt_cls_e;

  localparam logic [1:0] TS_NEUTRAL  = 2'b00;
  localparam logic [1:0] TS_ARMING   = 2'b01;
  localparam logic [1:0] TS_HELD_POS = 2'b10;
  localparam logic [1:0] TS_HELD_NEG = 2'b11;

endpackage

// File: rtl/tilt_classify.sv
// Combinational tilt classifier: maps one signed axis sample to POS/NEG/REL/BAND.
module tilt_classify
  import tilt_pkg::*;
#(
  parameter int THRESH = DEF_THRESH,
  parameter int HYST   = DEF_HYST
) (
  input  logic signed [15:0] sample_i,
  output tilt_cls_e          cls_o
);

  // 17-bit compares so negating the thresholds never wraps near -32768
  localparam logic signed [16:0] POS_TH = 17'(THRESH);
  localparam logic signed [16:0] NEG_TH = 17'(-THRESH);
  localparam logic signed [16:0] REL_HI = 17'(THRESH - HYST);
  localparam logic signed [16:0] REL_LO = 17'(-(THRESH - HYST));

  logic signed [16:0] s17;
  assign s17 = {sample_i[15], sample_i};

  always_comb begin
    cls_o = CLS_BAND;
    if (s17 >= POS_TH)                     cls_o = CLS_POS;
    else if (s17 <= NEG_TH)                cls_o = CLS_NEG;
    else if (s17 < REL_HI && s17 > REL_LO) cls_o = CLS_REL;
  end

endmodule

// File: rtl/tilt_entry_ctrl.sv
// Tilt-to-entry controller: qualifies held tilts, issues single and
// auto-repeat steps, and keeps a saturating signed entry value.
module tilt_entry_ctrl
  import tilt_pkg::*;
#(
  parameter int THRESH         = DEF_THRESH,
  parameter int HYST           = DEF_HYST,
  parameter int HOLD_SAMPLES   = 3,
  parameter int REPEAT_SAMPLES = 10,
  parameter int VAL_MAX        = 999,
  parameter int VAL_W          = 11
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sample_valid,
  input  logic signed [15:0]      sample,
  input  logic                    enable,
  input  logic                    load,
  input  logic signed [VAL_W-1:0] load_value,
  output logic signed [VAL_W-1:0] value,
  output logic                    step_up,
  output logic                    step_dn,
  output logic                    sat,
  output logic [1:0]              tilt_state
);

  localparam int HCW = (HOLD_SAMPLES < 2) ? 1 : $clog2(HOLD_SAMPLES + 1);
  localparam int RCW = (REPEAT_SAMPLES < 2) ? 1 : $clog2(REPEAT_SAMPLES + 1);
  localparam logic signed [VAL_W-1:0] VMAX = VAL_W'(VAL_MAX);
  localparam logic signed [VAL_W-1:0] VMIN = VAL_W'(-VAL_MAX);
  localparam logic FIRST_HIT = (HOLD_SAMPLES == 1);

  tilt_cls_e cls;
  tilt_st_e  state_q, state_d;
  logic [HCW-1:0] hcnt_q, hcnt_d, hinc;
  logic [RCW-1:0] rcnt_q, rcnt_d, rinc;
  logic up_req, dn_req, go_pos, go_neg;
  logic signed [VAL_W-1:0] value_q, value_d;
  logic step_up_q, step_up_d, step_dn_q, step_dn_d, sat_q, sat_d;

  tilt_classify #(.THRESH(THRESH), .HYST(HYST)) u_cls (
    .sample_i (sample),
    .cls_o    (cls)
  );

  assign hinc = hcnt_q + HCW'(1);
  assign rinc = rcnt_q + RCW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_NEUTRAL;
      hcnt_q  <= '0;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      rcnt_q  <= rcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    rcnt_d  = rcnt_q;
    up_req  = 1'b0;
    dn_req  = 1'b0;
    go_pos  = 1'b0;
    go_neg  = 1'b0;
    if (!enable) begin
      state_d = ST_NEUTRAL;
      hcnt_d  = '0;
      rcnt_d  = '0;
    end else if (sample_valid) begin
      unique case (state_q)
        ST_NEUTRAL: begin
          go_pos = (cls == CLS_POS);
          go_neg = (cls == CLS_NEG);
        end
        ST_ARM_POS, ST_ARM_NEG: begin
          if (cls == CLS_REL) begin
            state_d = ST_NEUTRAL;
            hcnt_d  = '0;
          end else if ((cls == CLS_POS) == (state_q == ST_ARM_POS) && cls != CLS_BAND) begin
            if (hinc == HCW'(HOLD_SAMPLES)) begin
              state_d = (state_q == ST_ARM_POS) ? ST_HELD_POS : ST_HELD_NEG;
              rcnt_d  = '0;
              up_req  = (state_q == ST_ARM_POS);
              dn_req  = (state_q == ST_ARM_NEG);
            end else begin
              hcnt_d = hinc;
            end
          end else if (cls != CLS_BAND) begin
            go_pos = (cls == CLS_POS);
            go_neg = (cls == CLS_NEG);
          end
        end
        ST_HELD_POS, ST_HELD_NEG: begin
          if (cls == CLS_REL) begin
            state_d = ST_NEUTRAL;
            hcnt_d  = '0;
            rcnt_d  = '0;
          end else if (state_q == ST_HELD_POS && cls == CLS_NEG) begin
            go_neg = 1'b1;
          end else if (state_q == ST_HELD_NEG && cls == CLS_POS) begin
            go_pos = 1'b1;
          end else if (rinc == RCW'(REPEAT_SAMPLES)) begin
            rcnt_d = '0;
            up_req = (state_q == ST_HELD_POS);
            dn_req = (state_q == ST_HELD_NEG);
          end else begin
            rcnt_d = rinc;
          end
        end
        default: state_d = ST_NEUTRAL;
      endcase
      // Entering an arm phase counts as the first qualifying sample
      if (go_pos || go_neg) begin
        hcnt_d  = HCW'(1);
        rcnt_d  = '0;
        state_d = go_pos ? (FIRST_HIT ? ST_HELD_POS : ST_ARM_POS)
                         : (FIRST_HIT ? ST_HELD_NEG : ST_ARM_NEG);
        up_req  = go_pos && FIRST_HIT;
        dn_req  = go_neg && FIRST_HIT;
      end
    end
  end

  always_comb begin
    value_d   = value_q;
    step_up_d = 1'b0;
    step_dn_d = 1'b0;
    if (load) begin
      if (load_value > VMAX)      value_d = VMAX;
      else if (load_value < VMIN) value_d = VMIN;
      else                        value_d = load_value;
    end else if (up_req && value_q != VMAX) begin
      value_d   = value_q + VAL_W'(1);
      step_up_d = 1'b1;
    end else if (dn_req && value_q != VMIN) begin
      value_d   = value_q - VAL_W'(1);
      step_dn_d = 1'b1;
    end
    sat_d = (value_d == VMAX) || (value_d == VMIN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      value_q   <= '0;
      step_up_q <= 1'b0;
      step_dn_q <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      value_q   <= value_d;
      step_up_q <= step_up_d;
      step_dn_q <= step_dn_d;
      sat_q     <= sat_d;
    end
  end

  always_comb begin
    value   = value_q;
    step_up = step_up_q;
    step_dn = step_dn_q;
    sat     = sat_q;
    unique case (state_q)
      ST_ARM_POS, ST_ARM_NEG: tilt_state = TS_ARMING;
      ST_HELD_POS:            tilt_state = TS_HELD_POS;
      ST_HELD_NEG:            tilt_state = TS_HELD_NEG;
      default:                tilt_state = TS_NEUTRAL;
    endcase
  end

endmodule

// File: tb/tb_tilt_entry_ctrl.sv
// Directed bench for tilt_entry_ctrl: hold/repeat, hysteresis, reversal,
// saturation, load priority, enable gating and reset behaviour.
module tb_tilt_entry_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, sample_valid, enable, load;
  logic signed [15:0] sample;
  logic signed [10:0] load_value, value;
  logic step_up, step_dn, sat;
  logic [1:0] tilt_state;

  int checks = 0, errors = 0;
  int up_cnt = 0, dn_cnt = 0;
  logic last_up, last_dn;

  tilt_entry_ctrl dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample(sample),
    .enable(enable), .load(load), .load_value(load_value), .value(value),
    .step_up(step_up), .step_dn(step_dn), .sat(sat), .tilt_state(tilt_state)
  );

  always @(negedge clk) begin
    if (step_up) up_cnt++;
    if (step_dn) dn_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // One strobed sample; last_up/last_dn capture the cycle after the strobe
  task automatic smp(input logic signed [15:0] s);
    sample_valid = 1'b1; sample = s;
    @(negedge clk);
    sample_valid = 1'b0;
    last_up = step_up; last_dn = step_dn;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic do_load(input logic signed [10:0] v);
    load = 1'b1; load_value = v;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; load = 1'b0; sample_valid = 1'b0;
    sample = '0; load_value = '0;
    repeat (2) @(negedge clk);
    checks++; if (value !== 11'sd0) begin errors++; $display("FAIL reset_value got %0d want 0", value); end
    checks++; if (tilt_state !== 2'b00) begin errors++; $display("FAIL reset_tilt got %b want 00", tilt_state); end
    checks++; if ({step_up, step_dn, sat} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {step_up, step_dn, sat}); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_hold_repeat();
    int u0;
    enable = 1'b1;
    u0 = up_cnt;
    smp(100);
    checks++; if (tilt_state !== 2'b01) begin errors++; $display("FAIL hold_arm got %b want 01", tilt_state); end
    smp(100);
    checks++; if (last_up !== 1'b0) begin errors++; $display("FAIL hold_early got %b want 0", last_up); end
    smp(100);
    checks++; if (last_up !== 1'b1) begin errors++; $display("FAIL hold_step got %b want 1", last_up); end
    checks++; if ($signed(value) !== 1) begin errors++; $display("FAIL hold_value got %0d want 1", value); end
    checks++; if (tilt_state !== 2'b10) begin errors++; $display("FAIL hold_tilt got %b want 10", tilt_state); end
    checks++; if (up_cnt - u0 !== 1) begin errors++; $display("FAIL hold_pulses got %0d want 1", up_cnt - u0); end
    repeat (9) smp(100);
    checks++; if (up_cnt - u0 !== 1) begin errors++; $display("FAIL repeat_early got %0d want 1", up_cnt - u0); end
    smp(100);
    checks++; if (last_up !== 1'b1) begin errors++; $display("FAIL repeat_step got %b want 1", last_up); end
    checks++; if ($signed(value) !== 2) begin errors++; $display("FAIL repeat_value got %0d want 2", value); end
  endtask

  task automatic test_reversal();
    int d0;
    d0 = dn_cnt;
    smp(-120);
    checks++; if (tilt_state !== 2'b01) begin errors++; $display("FAIL rev_arm got %b want 01", tilt_state); end
    smp(-120);
    smp(-120);
    checks++; if (last_dn !== 1'b1) begin errors++; $display("FAIL rev_step got %b want 1", last_dn); end
    checks++; if ($signed(value) !== 1) begin errors++; $display("FAIL rev_value got %0d want 1", value); end
    checks++; if (tilt_state !== 2'b11) begin errors++; $display("FAIL rev_tilt got %b want 11", tilt_state); end
    checks++; if (dn_cnt - d0 !== 1) begin errors++; $display("FAIL rev_pulses got %0d want 1", dn_cnt - d0); end
  endtask

  task automatic test_hysteresis();
    int u0;
    do_reset();
    u0 = up_cnt;
    smp(100); smp(100); smp(70);
    checks++; if (tilt_state !== 2'b01 || up_cnt != u0) begin errors++; $display("FAIL hyst_band got tilt %b pulses %0d want 01 0", tilt_state, up_cnt - u0); end
    smp(100);
    checks++; if (last_up !== 1'b1 || $signed(value) !== 1) begin errors++; $display("FAIL hyst_step got up %b value %0d want 1 1", last_up, value); end
    do_reset();
    u0 = up_cnt;
    smp(100); smp(50);
    checks++; if (tilt_state !== 2'b00) begin errors++; $display("FAIL hyst_rel got %b want 00", tilt_state); end
    checks++; if ($signed(value) !== 0 || up_cnt != u0) begin errors++; $display("FAIL hyst_rel_value got %0d pulses %0d want 0 0", value, up_cnt - u0); end
  endtask

  task automatic test_boundaries();
    do_reset();
    smp(80);
    checks++; if (tilt_state !== 2'b01) begin errors++; $display("FAIL bnd_80 got %b want 01", tilt_state); end
    smp(60);
    checks++; if (tilt_state !== 2'b01) begin errors++; $display("FAIL bnd_60 got %b want 01", tilt_state); end
    smp(59);
    checks++; if (tilt_state !== 2'b00) begin errors++; $display("FAIL bnd_59 got %b want 00", tilt_state); end
    smp(79);
    checks++; if (tilt_state !== 2'b00) begin errors++; $display("FAIL bnd_79 got %b want 00", tilt_state); end
    smp(-80); smp(-32768); smp(-32768);
    checks++; if (last_dn !== 1'b1 || $signed(value) !== -1) begin errors++; $display("FAIL bnd_min got dn %b value %0d want 1 -1", last_dn, value); end
  endtask

  task automatic test_saturation();
    int u0;
    do_reset();
    do_load(998);
    checks++; if ($signed(value) !== 998 || sat !== 1'b0) begin errors++; $display("FAIL sat_load got %0d sat %b want 998 0", value, sat); end
    u0 = up_cnt;
    repeat (3) smp(100);
    checks++; if ($signed(value) !== 999 || sat !== 1'b1) begin errors++; $display("FAIL sat_hit got %0d sat %b want 999 1", value, sat); end
    repeat (20) smp(100);
    checks++; if (up_cnt - u0 !== 1) begin errors++; $display("FAIL sat_pulses got %0d want 1", up_cnt - u0); end
    checks++; if ($signed(value) !== 999 || tilt_state !== 2'b10) begin errors++; $display("FAIL sat_hold got %0d tilt %b want 999 10", value, tilt_state); end
  endtask

  task automatic test_load_collision();
    int u0;
    do_reset();
    u0 = up_cnt;
    smp(100); smp(100);
    load = 1'b1; load_value = -11'sd1024; sample_valid = 1'b1; sample = 100;
    @(negedge clk);
    load = 1'b0; sample_valid = 1'b0;
    last_up = step_up;
    checks++; if (last_up !== 1'b0 || up_cnt != u0) begin errors++; $display("FAIL coll_pulse got %b want 0", last_up); end
    checks++; if ($signed(value) !== -999 || sat !== 1'b1) begin errors++; $display("FAIL coll_value got %0d sat %b want -999 1", value, sat); end
    checks++; if (tilt_state !== 2'b10) begin errors++; $display("FAIL coll_tilt got %b want 10", tilt_state); end
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    checks++; if (tilt_state !== 2'b00) begin errors++; $display("FAIL en_idle got %b want 00", tilt_state); end
    repeat (4) smp(100);
    checks++; if (tilt_state !== 2'b00 || $signed(value) !== -999 || up_cnt != u0) begin errors++; $display("FAIL en_frozen got tilt %b value %0d want 00 -999", tilt_state, value); end
    do_load(1023);
    checks++; if ($signed(value) !== 999 || sat !== 1'b1) begin errors++; $display("FAIL en_load got %0d want 999", value); end
    do_load(-5);
    checks++; if ($signed(value) !== -5 || sat !== 1'b0) begin errors++; $display("FAIL load_mid got %0d sat %b want -5 0", value, sat); end
    enable = 1'b1;
  endtask

  task automatic test_reset_mid_hold();
    int u0;
    do_load(5);
    smp(100); smp(100);
    do_reset();
    checks++; if ($signed(value) !== 0 || tilt_state !== 2'b00) begin errors++; $display("FAIL rst_mid got %0d tilt %b want 0 00", value, tilt_state); end
    u0 = up_cnt;
    smp(100); smp(100);
    checks++; if (tilt_state !== 2'b01 || up_cnt != u0) begin errors++; $display("FAIL rst_restart got tilt %b pulses %0d want 01 0", tilt_state, up_cnt - u0); end
    smp(100);
    checks++; if (last_up !== 1'b1 || $signed(value) !== 1) begin errors++; $display("FAIL rst_step got up %b value %0d want 1 1", last_up, value); end
  endtask

  initial begin
    test_reset();
    test_hold_repeat();
    test_reversal();
    test_hysteresis();
    test_boundaries();
    test_saturation();
    test_load_collision();
    test_reset_mid_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
